// File: rtl/instr_fetch_decoder_pkg.sv
// Shared types and decode helpers for instr_fetch_decoder.
// Holds the addressing-mode, ALU-operation and register-id enums that appear on
// the decoder ports, the decoded-information record, and the pure 6502 opcode
// decode functions (groups c=01, c=10, c=00; c=11 is always illegal).
package instr_fetch_decoder_pkg;

  typedef enum logic [3:0] {
    AM_IMPLIED = 4'd0,  AM_ACCUM  = 4'd1,  AM_IMM   = 4'd2,  AM_ZPG   = 4'd3,
    AM_ZPG_X   = 4'd4,  AM_ZPG_Y  = 4'd5,  AM_IND_X = 4'd6,  AM_IND_Y = 4'd7,
    AM_REL     = 4'd8,  AM_ABS    = 4'd9,  AM_ABS_X = 4'd10, AM_ABS_Y = 4'd11,
    AM_IND     = 4'd12
  } addressing_mode_t;

  typedef enum logic [3:0] {
    ALU_BYPASS_A = 4'd0,  ALU_OR  = 4'd1,  ALU_AND = 4'd2,  ALU_XOR = 4'd3,
    ALU_ADD      = 4'd4,  ALU_SUB = 4'd5,  ALU_CMP = 4'd6,  ALU_ASL = 4'd7,
    ALU_ROL      = 4'd8,  ALU_LSR = 4'd9,  ALU_ROR = 4'd10, ALU_INC = 4'd11,
    ALU_DEC      = 4'd12, ALU_BIT = 4'd13
  } alu_op_t;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0, A_REG = 3'd1, X_REG = 3'd2, Y_REG = 3'd3, SP_REG = 3'd4, P_REG = 3'd5
  } reg_id_t;

  typedef struct packed {
    addressing_mode_t am;
    alu_op_t          alu;
    reg_id_t          src;
    reg_id_t          dst;
    logic             we_rf;
    logic             we_mem;
    logic             illegal;
  } dec_info_t;

  localparam dec_info_t ILL_INFO = '{am: AM_IMPLIED, alu: ALU_BYPASS_A, src: REG_NONE,
                                     dst: REG_NONE, we_rf: 1'b0, we_mem: 1'b0, illegal: 1'b1};

  function automatic dec_info_t mk(input addressing_mode_t am, input alu_op_t alu,
                                   input reg_id_t src, input reg_id_t dst,
                                   input logic we_rf, input logic we_mem);
    mk = '{am: am, alu: alu, src: src, dst: dst, we_rf: we_rf, we_mem: we_mem, illegal: 1'b0};
  endfunction

  // Instruction length follows directly from the addressing mode.
  function automatic logic [1:0] am_len(input addressing_mode_t am);
    case (am)
      AM_IMPLIED, AM_ACCUM:             am_len = 2'd1;
      AM_ABS, AM_ABS_X, AM_ABS_Y, AM_IND: am_len = 2'd3;
      default:                          am_len = 2'd2;
    endcase
  endfunction

  // c=10: shifts, INC/DEC, STX/LDX plus the single-byte xA transfers.
  function automatic dec_info_t decode_g2(input logic [2:0] a, input logic [2:0] b);
    addressing_mode_t am;
    alu_op_t          alu;
    logic             ok;
    dec_info_t        d;
    case (a)
      3'd0:    alu = ALU_ASL;
      3'd1:    alu = ALU_ROL;
      3'd2:    alu = ALU_LSR;
      3'd3:    alu = ALU_ROR;
      3'd6:    alu = ALU_DEC;
      3'd7:    alu = ALU_INC;
      default: alu = ALU_BYPASS_A;
    endcase
    ok = 1'b1;
    am = AM_IMPLIED;
    case (b)
      3'd0:    begin am = AM_IMM; ok = (a == 3'd5); end
      3'd1:    am = AM_ZPG;
      3'd3:    am = AM_ABS;
      // STX/LDX index with Y where the rest of the group uses X
      3'd5:    am = (a[2:1] == 2'b10) ? AM_ZPG_Y : AM_ZPG_X;
      3'd7:    begin am = (a == 3'd5) ? AM_ABS_Y : AM_ABS_X; ok = (a != 3'd4); end
      default: ok = 1'b0;
    endcase
    if (!ok)            d = ILL_INFO;
    else if (a == 3'd4) d = mk(am, ALU_BYPASS_A, X_REG, REG_NONE, 1'b0, 1'b1);
    else if (a == 3'd5) d = mk(am, ALU_BYPASS_A, REG_NONE, X_REG, 1'b1, 1'b0);
    else                d = mk(am, alu, REG_NONE, REG_NONE, 1'b0, 1'b1);
    // b=010 is accumulator for the shifts and implied register ops above that
    if (b == 3'd2) begin
      case (a)
        3'd4:    d = mk(AM_IMPLIED, ALU_BYPASS_A, X_REG, A_REG, 1'b1, 1'b0);    // TXA
        3'd5:    d = mk(AM_IMPLIED, ALU_BYPASS_A, A_REG, X_REG, 1'b1, 1'b0);    // TAX
        3'd6:    d = mk(AM_IMPLIED, ALU_DEC, X_REG, X_REG, 1'b1, 1'b0);         // DEX
        3'd7:    d = mk(AM_IMPLIED, ALU_BYPASS_A, REG_NONE, REG_NONE, 1'b0, 1'b0); // NOP
        default: d = mk(AM_ACCUM, alu, A_REG, A_REG, 1'b1, 1'b0);
      endcase
    end else if (b == 3'd6) begin
      case (a)
        3'd4:    d = mk(AM_IMPLIED, ALU_BYPASS_A, X_REG, SP_REG, 1'b1, 1'b0);   // TXS
        3'd5:    d = mk(AM_IMPLIED, ALU_BYPASS_A, SP_REG, X_REG, 1'b1, 1'b0);   // TSX
        default: d = ILL_INFO;
      endcase
    end else begin
      d = d;
    end
    decode_g2 = d;
  endfunction

  // c=00: irregular, so decoded from the full opcode.
  function automatic dec_info_t decode_g3(input logic [7:0] op);
    case (op)
      8'h00: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, P_REG, REG_NONE, 1'b0, 1'b1);   // BRK
      8'h20: decode_g3 = mk(AM_ABS, ALU_BYPASS_A, REG_NONE, REG_NONE, 1'b0, 1'b1);    // JSR
      8'h40, 8'h28, 8'h18, 8'h38, 8'h58, 8'h78, 8'hB8, 8'hD8, 8'hF8:
             decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, REG_NONE, P_REG, 1'b1, 1'b0);   // RTI/PLP/flags
      8'h60: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, REG_NONE, REG_NONE, 1'b0, 1'b0); // RTS
      8'h08: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, P_REG, REG_NONE, 1'b0, 1'b1);   // PHP
      8'h48: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, A_REG, REG_NONE, 1'b0, 1'b1);   // PHA
      8'h68: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, REG_NONE, A_REG, 1'b1, 1'b0);   // PLA
      8'h88: decode_g3 = mk(AM_IMPLIED, ALU_DEC, Y_REG, Y_REG, 1'b1, 1'b0);           // DEY
      8'hA8: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, A_REG, Y_REG, 1'b1, 1'b0);      // TAY
      8'hC8: decode_g3 = mk(AM_IMPLIED, ALU_INC, Y_REG, Y_REG, 1'b1, 1'b0);           // INY
      8'hE8: decode_g3 = mk(AM_IMPLIED, ALU_INC, X_REG, X_REG, 1'b1, 1'b0);           // INX
      8'h98: decode_g3 = mk(AM_IMPLIED, ALU_BYPASS_A, Y_REG, A_REG, 1'b1, 1'b0);      // TYA
      8'h24: decode_g3 = mk(AM_ZPG, ALU_BIT, A_REG, REG_NONE, 1'b0, 1'b0);
      8'h2C: decode_g3 = mk(AM_ABS, ALU_BIT, A_REG, REG_NONE, 1'b0, 1'b0);
      8'h4C: decode_g3 = mk(AM_ABS, ALU_BYPASS_A, REG_NONE, REG_NONE, 1'b0, 1'b0);
      8'h6C: decode_g3 = mk(AM_IND, ALU_BYPASS_A, REG_NONE, REG_NONE, 1'b0, 1'b0);
      8'h84: decode_g3 = mk(AM_ZPG, ALU_BYPASS_A, Y_REG, REG_NONE, 1'b0, 1'b1);
      8'h8C: decode_g3 = mk(AM_ABS, ALU_BYPASS_A, Y_REG, REG_NONE, 1'b0, 1'b1);
      8'h94: decode_g3 = mk(AM_ZPG_X, ALU_BYPASS_A, Y_REG, REG_NONE, 1'b0, 1'b1);
      8'hA0: decode_g3 = mk(AM_IMM, ALU_BYPASS_A, REG_NONE, Y_REG, 1'b1, 1'b0);
      8'hA4: decode_g3 = mk(AM_ZPG, ALU_BYPASS_A, REG_NONE, Y_REG, 1'b1, 1'b0);
      8'hAC: decode_g3 = mk(AM_ABS, ALU_BYPASS_A, REG_NONE, Y_REG, 1'b1, 1'b0);
      8'hB4: decode_g3 = mk(AM_ZPG_X, ALU_BYPASS_A, REG_NONE, Y_REG, 1'b1, 1'b0);
      8'hBC: decode_g3 = mk(AM_ABS_X, ALU_BYPASS_A, REG_NONE, Y_REG, 1'b1, 1'b0);
      8'hC0: decode_g3 = mk(AM_IMM, ALU_CMP, Y_REG, REG_NONE, 1'b0, 1'b0);
      8'hC4: decode_g3 = mk(AM_ZPG, ALU_CMP, Y_REG, REG_NONE, 1'b0, 1'b0);
      8'hCC: decode_g3 = mk(AM_ABS, ALU_CMP, Y_REG, REG_NONE, 1'b0, 1'b0);
      8'hE0: decode_g3 = mk(AM_IMM, ALU_CMP, X_REG, REG_NONE, 1'b0, 1'b0);
      8'hE4: decode_g3 = mk(AM_ZPG, ALU_CMP, X_REG, REG_NONE, 1'b0, 1'b0);
      8'hEC: decode_g3 = mk(AM_ABS, ALU_CMP, X_REG, REG_NONE, 1'b0, 1'b0);
      // branches are xxy10000
      default: decode_g3 = (op[4:0] == 5'b10000) ?
                           mk(AM_REL, ALU_BYPASS_A, REG_NONE, REG_NONE, 1'b0, 1'b0) : ILL_INFO;
    endcase
  endfunction

  // Full decode; g2g3=0 leaves only group 1 legal.
  function automatic dec_info_t decode_op(input logic [7:0] op, input logic g2g3);
    addressing_mode_t am;
    alu_op_t          alu;
    dec_info_t        d;
    case (op[4:2])
      3'd0:    am = AM_IND_X;
      3'd1:    am = AM_ZPG;
      3'd2:    am = AM_IMM;
      3'd3:    am = AM_ABS;
      3'd4:    am = AM_IND_Y;
      3'd5:    am = AM_ZPG_X;
      3'd6:    am = AM_ABS_Y;
      default: am = AM_ABS_X;
    endcase
    case (op[7:5])
      3'd0:    alu = ALU_OR;
      3'd1:    alu = ALU_AND;
      3'd2:    alu = ALU_XOR;
      3'd3:    alu = ALU_ADD;
      3'd6:    alu = ALU_CMP;
      3'd7:    alu = ALU_SUB;
      default: alu = ALU_BYPASS_A;
    endcase
    case (op[1:0])
      2'b01: d = (op == 8'h89) ? ILL_INFO :
                 mk(am, alu, A_REG, A_REG, (op[7:5] != 3'd4) && (op[7:5] != 3'd6), op[7:5] == 3'd4);
      2'b10: d = g2g3 ? decode_g2(op[7:5], op[4:2]) : ILL_INFO;
      2'b00: d = g2g3 ? decode_g3(op) : ILL_INFO;
      default: d = ILL_INFO;
    endcase
    decode_op = d;
  endfunction

endpackage

// File: rtl/instr_fetch_decoder.sv
// Byte-stream 6502 instruction assembler and decoder with a small bundle queue.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   byte_valid_i/byte_i/byte_ready_o  fetch byte stream (accepted on valid&ready)
//   flush_i/flush_pc_i           redirect: drop partial instruction and queue, load pc
//   dec_valid_o/dec_ready_i      queue head handshake
//   dec_*_o                      head bundle payload (opcode, pc, len, imm, decode)
//   level_o                      queue occupancy
module instr_fetch_decoder
  import instr_fetch_decoder_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int QUEUE_DEPTH = 2,
  parameter bit DECODE_G2G3 = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           byte_valid_i,
  input  logic [BYTE_W-1:0]              byte_i,
  output logic                           byte_ready_o,
  input  logic                           flush_i,
  input  logic [ADDR_W-1:0]              flush_pc_i,
  output logic                           dec_valid_o,
  input  logic                           dec_ready_i,
  output logic [BYTE_W-1:0]              dec_opcode_o,
  output logic [ADDR_W-1:0]              dec_pc_o,
  output logic [1:0]                     dec_len_o,
  output logic [2*BYTE_W-1:0]            dec_imm_o,
  output addressing_mode_t               dec_addr_mode_o,
  output alu_op_t                        dec_alu_op_o,
  output reg_id_t                        dec_src_reg_o,
  output reg_id_t                        dec_dst_reg_o,
  output logic                           dec_we_rf_o,
  output logic                           dec_we_mem_o,
  output logic                           dec_illegal_o,
  output logic [$clog2(QUEUE_DEPTH):0]   level_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {S_OPC = 2'd0, S_OP1 = 2'd1, S_OP2 = 2'd2} state_t;

  typedef struct packed {
    logic [BYTE_W-1:0]   opcode;
    logic [ADDR_W-1:0]   pc;
    logic [1:0]          len;
    logic [2*BYTE_W-1:0] imm;
    dec_info_t           info;
  } bundle_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_start_q;
  logic [BYTE_W-1:0] opc_q, imm_lo_q;
  dec_info_t         info_q, dec_info_s;
  bundle_t           q_mem_q [QUEUE_DEPTH];
  bundle_t           push_b_s, head_s;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              accept_s, pop_s, push_s;

  // Ready depends only on occupancy so the consumer cannot combinationally gate fetch.
  assign byte_ready_o = (level_q < LW'(QUEUE_DEPTH));
  assign accept_s     = byte_valid_i & byte_ready_o & ~flush_i;
  assign pop_s        = (level_q != {LW{1'b0}}) & dec_ready_i & ~flush_i;
  assign dec_info_s   = decode_op(byte_i[7:0], DECODE_G2G3);
  assign level_d      = level_q + LW'(push_s) - LW'(pop_s);

  // Assemble the bundle being completed this cycle and choose the next FSM state.
  always_comb begin
    state_d         = state_q;
    push_s          = 1'b0;
    push_b_s        = '0;
    push_b_s.opcode = opc_q;
    push_b_s.pc     = pc_start_q;
    push_b_s.info   = info_q;
    push_b_s.len    = am_len(info_q.am);
    case (state_q)
      S_OPC: begin
        push_b_s.opcode = byte_i;
        push_b_s.pc     = pc_q;
        push_b_s.info   = dec_info_s;
        push_b_s.len    = am_len(dec_info_s.am);
        if (accept_s) begin
          if (am_len(dec_info_s.am) == 2'd1) push_s  = 1'b1;
          else                               state_d = S_OP1;
        end else begin
          state_d = S_OPC;
        end
      end
      S_OP1: begin
        push_b_s.imm = {{BYTE_W{1'b0}}, byte_i};
        if (accept_s) begin
          if (am_len(info_q.am) == 2'd2) begin
            push_s  = 1'b1;
            state_d = S_OPC;
          end else begin
            state_d = S_OP2;
          end
        end else begin
          state_d = S_OP1;
        end
      end
      S_OP2: begin
        push_b_s.imm = {byte_i, imm_lo_q};
        if (accept_s) begin
          push_s  = 1'b1;
          state_d = S_OPC;
        end else begin
          state_d = S_OP2;
        end
      end
      default: state_d = S_OPC;
    endcase
  end

  // All state: assembler FSM, pc, and the bundle queue; flush outranks everything but reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_OPC;
      pc_q       <= {ADDR_W{1'b0}};
      pc_start_q <= {ADDR_W{1'b0}};
      opc_q      <= {BYTE_W{1'b0}};
      imm_lo_q   <= {BYTE_W{1'b0}};
      info_q     <= '0;
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) q_mem_q[i] <= '0;
    end else if (flush_i) begin
      state_q <= S_OPC;
      pc_q    <= flush_pc_i;
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      level_q <= {LW{1'b0}};
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (accept_s) pc_q <= pc_q + ADDR_W'(1);
      if (accept_s && (state_q == S_OPC)) begin
        opc_q      <= byte_i;
        pc_start_q <= pc_q;
        info_q     <= dec_info_s;
      end
      if (accept_s && (state_q == S_OP1)) imm_lo_q <= byte_i;
      if (push_s) begin
        q_mem_q[wptr_q] <= push_b_s;
        wptr_q          <= wptr_q + PW'(1);
      end
      if (pop_s) rptr_q <= rptr_q + PW'(1);
    end
  end

  assign head_s          = q_mem_q[rptr_q];
  assign dec_valid_o     = (level_q != {LW{1'b0}});
  assign level_o         = level_q;
  assign dec_opcode_o    = head_s.opcode;
  assign dec_pc_o        = head_s.pc;
  assign dec_len_o       = head_s.len;
  assign dec_imm_o       = head_s.imm;
  assign dec_addr_mode_o = head_s.info.am;
  assign dec_alu_op_o    = head_s.info.alu;
  assign dec_src_reg_o   = head_s.info.src;
  assign dec_dst_reg_o   = head_s.info.dst;
  assign dec_we_rf_o     = head_s.info.we_rf;
  assign dec_we_mem_o    = head_s.info.we_mem;
  assign dec_illegal_o   = head_s.info.illegal;

endmodule
